// File: rtl/qbus_pkg.sv
// qbus_pkg: shared types and constants for the Q-bus target.
//   qbus_state_e : transaction FSM states
//   BE_LO/BE_HI/BE_WORD : memory-port byte-enable encodings
package qbus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        RD_REQ   = 3'd2,
        RD_SETUP = 3'd3,
        RD_RPLY  = 3'd4,
        WR_REQ   = 3'd5,
        WR_RPLY  = 3'd6,
        DONE     = 3'd7
    } qbus_state_e;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    // Byte writes select one lane from the byte address LSB; word writes use both.
    function automatic logic [1:0] write_be(input logic is_byte, input logic a0);
        if (!is_byte) return BE_WORD;
        return a0 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/qbus_sync.sv
// qbus_sync: W-bit wide, STAGES-deep flop-chain synchronizer.
//   clk, rst : clock, asynchronous active-high reset (flops reset to 1,
//              the idle level of the inverted Q-bus lines)
//   d        : asynchronous input vector
//   q        : synchronized output vector (STAGES cycles of latency)
module qbus_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '1;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/qbus_slave.sv
// qbus_slave: Q-bus target answering DATI, DATO(B) and DATIO(B) and bridging
// each transaction to a synchronous memory/register port.
//   pin_clk, pin_rst     : clock, asynchronous active-high reset
//   pin_ad_in_n          : inverted AD bus from the pins
//   pin_ad_out_n/_oe     : inverted AD drive value and its output enable
//   pin_sync_n/din_n/dout_n/wtbt_n : bus strobes and status (active low)
//   pin_rply_n           : reply (made open-drain by the board top)
//   mem_*                : memory port (word address, data, byte enables,
//                          rd/wr request, ack pulse, read data)
//   dbg_state            : current FSM state, for observation only
//
// Memory handshake: mem_rd or mem_wr is raised with address/data/enables
// stable and stays high until the cycle in which mem_ack = 1 is sampled;
// mem_rdata is only valid in that ack cycle. A request never drops early
// except on reset, after which a stray ack is ignored because the FSM is idle.
module qbus_slave
    import qbus_pkg::*;
#(
    parameter int            AW          = 16,
    parameter logic [AW-1:0] BASE        = 16'o000000,
    parameter logic [AW-1:0] MASK        = 16'o170000,
    parameter int            SETUP       = 2,
    parameter int            SYNC_STAGES = 2
) (
    input  logic              pin_clk,
    input  logic              pin_rst,
    input  logic [15:0]       pin_ad_in_n,
    output logic [15:0]       pin_ad_out_n,
    output logic              pin_ad_oe,
    input  logic              pin_sync_n,
    input  logic              pin_din_n,
    input  logic              pin_dout_n,
    input  logic              pin_wtbt_n,
    output logic              pin_rply_n,
    output logic [AW-2:0]     mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output qbus_state_e       dbg_state
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);

    // Synchronized bus inputs, still active low.
    logic [15:0] ad_s;
    logic        sync_s, din_s, dout_s, wtbt_s;

    qbus_sync #(.W(20), .STAGES(SYNC_STAGES)) u_sync (
        .clk (pin_clk),
        .rst (pin_rst),
        .d   ({pin_ad_in_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}),
        .q   ({ad_s, sync_s, din_s, dout_s, wtbt_s})
    );

    qbus_state_e   state, next_state;
    logic          sync_d;
    logic [AW-1:0] addr;
    logic [15:0]   wdata, rdata;
    logic          byte_wr;
    logic [7:0]    setup_cnt;

    logic [AW-1:0] ad_addr;
    logic          sync_fall, hit;

    assign ad_addr   = ~ad_s[AW-1:0];
    assign sync_fall = sync_d & ~sync_s;
    assign hit       = ((ad_addr & MASK) == (BASE & MASK));

    // State register.
    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (sync_fall) next_state = hit ? ADDR : DONE;
            // SYNC negation ends the frame; DIN wins over DOUT when both show.
            ADDR: begin
                if (sync_s)       next_state = IDLE;
                else if (!din_s)  next_state = RD_REQ;
                else if (!dout_s) next_state = WR_REQ;
            end
            // A frame abandoned mid-request still finishes the memory access
            // but gets no reply.
            RD_REQ:   if (mem_ack) next_state = sync_s ? IDLE : RD_SETUP;
            RD_SETUP: if (setup_cnt == SETUP_LAST) next_state = RD_RPLY;
            // Back to ADDR so a DOUT in the same frame forms a DATIO.
            RD_RPLY:  if (din_s) next_state = ADDR;
            WR_REQ:   if (mem_ack) next_state = sync_s ? IDLE : WR_RPLY;
            WR_RPLY:  if (dout_s) next_state = DONE;
            DONE:     if (sync_s) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Datapath registers captured at specific FSM transitions.
    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            sync_d    <= 1'b1;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            byte_wr   <= 1'b0;
            setup_cnt <= '0;
        end else begin
            sync_d <= sync_s;
            if (state == IDLE && sync_fall) addr <= ad_addr;
            if (state == ADDR && next_state == WR_REQ) begin
                wdata   <= ~ad_s;
                byte_wr <= ~wtbt_s;
            end
            if (state == RD_REQ && mem_ack) rdata <= mem_rdata;
            setup_cnt <= (state == RD_SETUP) ? setup_cnt + 8'd1 : 8'd0;
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        pin_rply_n   = 1'b1;
        pin_ad_oe    = 1'b0;
        pin_ad_out_n = 16'hFFFF;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_be       = 2'b00;
        unique case (state)
            RD_REQ: begin
                mem_rd = 1'b1;
                mem_be = BE_WORD;
            end
            RD_SETUP: begin
                pin_ad_oe    = 1'b1;
                pin_ad_out_n = ~rdata;
            end
            RD_RPLY: begin
                pin_ad_oe    = 1'b1;
                pin_ad_out_n = ~rdata;
                pin_rply_n   = 1'b0;
            end
            WR_REQ: begin
                mem_wr = 1'b1;
                mem_be = write_be(byte_wr, addr[0]);
            end
            WR_RPLY: pin_rply_n = 1'b0;
            default: ;
        endcase
    end

    assign mem_addr  = addr[AW-1:1];
    assign mem_wdata = wdata;
    assign dbg_state = state;

endmodule

// File: tb/tb_qbus_slave.sv
// tb_qbus_slave: directed bench for qbus_slave. A memory responder process
// acknowledges requests and checks each against an expected-request queue;
// the main initial block drives Q-bus frames step by step.
module tb_qbus_slave;
    import qbus_pkg::*;

    localparam int AW          = 16;
    localparam int SETUP       = 2;
    localparam int SYNC_STAGES = 2;
    localparam int W           = 34;   // {wr, word addr[14:0], be, wdata}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0]   pin_ad_in_n, pin_ad_out_n;
    logic          pin_ad_oe, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_rply_n;
    logic [AW-2:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic [1:0]    mem_be;
    logic          mem_rd, mem_wr, mem_ack;
    qbus_state_e   dbg_state;

    qbus_slave #(
        .AW(AW), .BASE(16'o000000), .MASK(16'o170000),
        .SETUP(SETUP), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .pin_clk      (clk),
        .pin_rst      (rst),
        .pin_ad_in_n  (pin_ad_in_n),
        .pin_ad_out_n (pin_ad_out_n),
        .pin_ad_oe    (pin_ad_oe),
        .pin_sync_n   (pin_sync_n),
        .pin_din_n    (pin_din_n),
        .pin_dout_n   (pin_dout_n),
        .pin_wtbt_n   (pin_wtbt_n),
        .pin_rply_n   (pin_rply_n),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           ack_lat  = 1;
    logic [15:0]  rd_value = 16'h0000;
    logic [W-1:0] resp_obs;
    logic         resp_held;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] req(input logic wr, input logic [15:0] a,
                                         input logic [1:0] be, input logic [15:0] d);
        return {wr, a[15:1], be, d};
    endfunction

    // Memory responder: checks each request, then acks after ack_lat cycles.
    always begin
        @(posedge clk); #2;
        if (rst === 1'b0 && (mem_rd === 1'b1 || mem_wr === 1'b1)) begin
            resp_obs = {mem_wr, mem_addr, mem_wr ? mem_be : 2'b00, mem_wr ? mem_wdata : 16'h0};
            if (exp_q.size() == 0) check("unexpected_req", W'(exp_q.size()), 34'd1);
            else                   check("mem_req", resp_obs, exp_q.pop_front());
            resp_held = 1'b1;
            repeat (ack_lat - 1) begin
                @(posedge clk); #2;
                if (!(mem_rd === 1'b1 || mem_wr === 1'b1)) resp_held = 1'b0;
            end
            check("req_held_until_ack", W'(resp_held), 34'd1);
            mem_rdata = rd_value;
            mem_ack   = 1'b1;
            @(posedge clk); #2;
            mem_ack   = 1'b0;
            mem_rdata = 16'h0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic bus_release();
        pin_ad_in_n = 16'hFFFF;
        pin_sync_n  = 1'b1;
        pin_din_n   = 1'b1;
        pin_dout_n  = 1'b1;
        pin_wtbt_n  = 1'b1;
    endtask

    task automatic addr_phase(input logic [15:0] a);
        pin_ad_in_n = ~a;
        step();
        pin_sync_n = 1'b0;
        repeat (3) step();
        pin_ad_in_n = 16'hFFFF;
    endtask

    task automatic wait_rply(input logic lvl, input string tag, output int n);
        n = 0;
        while (pin_rply_n !== lvl && n < 60) begin
            step();
            n++;
        end
        check(tag, W'(pin_rply_n), W'(lvl));
    endtask

    task automatic wait_oe(input string tag);
        int n = 0;
        while (pin_ad_oe !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check(tag, W'(pin_ad_oe), 34'd1);
    endtask

    task automatic frame_end(input string tag);
        bus_release();
        repeat (6) step();
        check(tag, W'(exp_q.size()), 34'd0);
    endtask

    task automatic watch_quiet(input int cycles, output logic bad);
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (pin_rply_n !== 1'b1 || pin_ad_oe !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0)
                bad = 1'b1;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic wtbt_n,
                            input logic [1:0] be, input string tag);
        int n;
        ack_lat = 2;
        exp_q.push_back(req(1'b1, a, be, d));
        addr_phase(a);
        pin_ad_in_n = ~d;
        pin_wtbt_n  = wtbt_n;
        pin_dout_n  = 1'b0;
        wait_rply(1'b0, {tag, "_rply"}, n);
        check({tag, "_wr_dropped"}, W'(mem_wr), 34'd0);
        pin_dout_n = 1'b1;
        wait_rply(1'b1, {tag, "_rply_release"}, n);
        check({tag, "_release_delay"}, W'(n), W'(SYNC_STAGES + 1));
        frame_end({tag, "_done"});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   n;
        logic bad;

        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        bus_release();
        repeat (3) step();
        check("rst_rply",   W'(pin_rply_n),   34'd1);
        check("rst_oe",     W'(pin_ad_oe),    34'd0);
        check("rst_ad_out", W'(pin_ad_out_n), 34'hFFFF);
        check("rst_rd",     W'(mem_rd),       34'd0);
        check("rst_wr",     W'(mem_wr),       34'd0);
        check("rst_be",     W'(mem_be),       34'd0);
        check("rst_state",  W'(dbg_state),    W'(IDLE));
        rst = 1'b0;
        repeat (3) step();

        // Word DATI at 0o100, 3-cycle ack latency.
        ack_lat  = 3;
        rd_value = 16'o123456;
        exp_q.push_back(req(1'b0, 16'o000100, 2'b00, 16'h0));
        addr_phase(16'o000100);
        pin_din_n = 1'b0;
        wait_oe("dati_oe");
        check("dati_ad_value", W'(pin_ad_out_n), W'(16'(~16'o123456)));
        check("dati_rply_in_setup", W'(pin_rply_n), 34'd1);
        wait_rply(1'b0, "dati_rply", n);
        check("dati_setup_cycles", W'(n), W'(SETUP));
        pin_din_n = 1'b1;
        wait_rply(1'b1, "dati_rply_release", n);
        check("dati_release_delay", W'(n), W'(SYNC_STAGES + 1));
        check("dati_oe_release", W'(pin_ad_oe), 34'd0);
        frame_end("dati_done");

        // Word DATO and both byte-lane DATOBs.
        do_write(16'o000200, 16'o052525, 1'b1, 2'b11, "dato");
        do_write(16'o000201, 16'o177000, 1'b0, 2'b10, "datob_hi");
        do_write(16'o000200, 16'o000125, 1'b0, 2'b01, "datob_lo");

        // Address outside the window: no memory access, no reply, no drive.
        addr_phase(16'o170000);
        pin_din_n = 1'b0;
        watch_quiet(20, bad);
        check("miss_quiet", W'(bad), 34'd0);
        frame_end("miss_done");

        // DATIO at 0o300: read then write within one SYNC frame.
        ack_lat  = 1;
        rd_value = 16'o000777;
        exp_q.push_back(req(1'b0, 16'o000300, 2'b00, 16'h0));
        exp_q.push_back(req(1'b1, 16'o000300, 2'b11, 16'o001000));
        addr_phase(16'o000300);
        pin_din_n = 1'b0;
        wait_oe("datio_oe");
        check("datio_ad_value", W'(pin_ad_out_n), W'(16'(~16'o000777)));
        wait_rply(1'b0, "datio_rd_rply", n);
        pin_din_n = 1'b1;
        wait_rply(1'b1, "datio_rd_release", n);
        check("datio_read_left", W'(exp_q.size()), 34'd1);
        pin_ad_in_n = 16'(~16'o001000);
        pin_wtbt_n  = 1'b1;
        pin_dout_n  = 1'b0;
        wait_rply(1'b0, "datio_wr_rply", n);
        pin_dout_n = 1'b1;
        wait_rply(1'b1, "datio_wr_release", n);
        frame_end("datio_done");

        // Strobe without a SYNC edge is ignored.
        pin_din_n = 1'b0;
        watch_quiet(12, bad);
        check("stray_strobe_quiet", W'(bad), 34'd0);
        bus_release();
        repeat (3) step();

        // Reset while replying to a read releases the bus at once.
        ack_lat  = 2;
        rd_value = 16'o111111;
        exp_q.push_back(req(1'b0, 16'o000100, 2'b00, 16'h0));
        addr_phase(16'o000100);
        pin_din_n = 1'b0;
        wait_rply(1'b0, "rst_pre_rply", n);
        rst = 1'b1;
        #1;
        check("rst_mid_rply",   W'(pin_rply_n),   34'd1);
        check("rst_mid_oe",     W'(pin_ad_oe),    34'd0);
        check("rst_mid_ad_out", W'(pin_ad_out_n), 34'hFFFF);
        check("rst_mid_state",  W'(dbg_state),    W'(IDLE));
        bus_release();
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        check("rst_mid_queue", W'(exp_q.size()), 34'd0);
        do_write(16'o000200, 16'o000001, 1'b1, 2'b11, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit in case a bounded wait is ever defeated.
    initial begin
        #500000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qbus_slave.md
Name: qbus_slave

Overview:
Q-bus target (responder) for the am4 initiator. It decodes the address phase, answers DATI, DATO(B) and DATIO(B) transactions with RPLY, and bridges each transaction to a simple synchronous memory/register port. It sits between the board-level Q-bus pins and on-chip RAM or peripheral registers. The board top wraps ad_out_n/ad_oe into the inout AD bus.

Parameters:
AW, 16, Q-bus address width in bits (byte address)
BASE, 16'o000000, window base address, byte granular
MASK, 16'o170000, address bits compared against BASE; all other bits pass through to the memory port
SETUP, 2, pin_clk cycles from data driven on AD to RPLY asserted on read
SYNC_STAGES, 2, synchronizer depth on every bus input, minimum 2

Ports:
pin_clk  in  1  system clock
pin_rst  in  1  asynchronous reset, active-high
pin_ad_in_n  in  16  inverted AD bus as sampled from the pins
pin_ad_out_n  out  16  inverted AD value to drive
pin_ad_oe  out  1  AD output enable, 1 = drive
pin_sync_n  in  1  address strobe
pin_din_n  in  1  data input strobe
pin_dout_n  in  1  data output strobe
pin_wtbt_n  in  1  write/byte status
pin_rply_n  out  1  reply; the top module converts this to open-drain
mem_addr  out  AW-1  word address, addr[AW-1:1]
mem_wdata  out  16  write data
mem_be  out  2  byte enables: bit0 = low byte, bit1 = high byte
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  16  read data, valid when mem_ack = 1

Behaviour:
- Reset values (asynchronous, pin_rst = 1): pin_rply_n = 1, pin_ad_oe = 0, pin_ad_out_n = 16'hFFFF, mem_rd = 0, mem_wr = 0, mem_be = 0, state = IDLE, synchronizers = 1. Reset mid-transaction releases the bus immediately. Any pending mem request is dropped, and a later mem_ack is ignored.
- Every bus input, including all AD bits, passes through a SYNC_STAGES flop chain. "Asserted" below always refers to the synchronized value being 0.
- IDLE: on a SYNC falling edge, latch addr = ~ad_in and compute hit = ((addr & MASK) == (BASE & MASK)).
  - hit = 0 → go to DONE without responding.
  - hit = 1 → go to ADDR.
- ADDR: wait for DIN or DOUT asserted.
  - DIN → RD_REQ.
  - DOUT → WR_REQ; capture wdata = ~ad_in and byte = ~wtbt_n in the same cycle.
  - SYNC negated → IDLE.
- RD_REQ: mem_rd = 1 from the first cycle in the state until mem_ack. On mem_ack, latch mem_rdata and go to RD_SETUP.
- RD_SETUP: pin_ad_oe = 1 and pin_ad_out_n = ~rdata, starting the cycle after the ack. After SETUP cycles, go to RD_RPLY.
- RD_RPLY: pin_rply_n = 0. When DIN negates, the next cycle sets pin_rply_n = 1 and pin_ad_oe = 0, then returns to ADDR. Returning to ADDR allows a DOUT in the same SYNC frame (DATIO).
- WR_REQ: mem_wr = 1 until mem_ack.
  - Word write: mem_be = 2'b11.
  - Byte write: mem_be = 2'b01 if addr[0] = 0, else 2'b10. mem_wdata = wdata unshifted; the initiator already places the byte in the correct lane.
  - The cycle after the ack, go to WR_RPLY.
- WR_RPLY: pin_rply_n = 0 until DOUT negates, then pin_rply_n = 1 and go to DONE.
- DONE: wait for SYNC negated, then IDLE. A second strobe within the same frame after a write is ignored.
- mem_addr = addr[AW-1:1] for the whole frame. addr[0] only selects byte lanes.
- DIN and DOUT asserted simultaneously in ADDR: DIN has priority.
- SYNC negating during RD_REQ or WR_REQ: the mem request is still completed, the reply is suppressed, and the FSM goes to IDLE after mem_ack.
- A strobe asserted while in IDLE without a preceding SYNC edge is ignored.

Decomposition:
- Package qbus_pkg holds:
  - the state enum (IDLE, ADDR, RD_REQ, RD_SETUP, RD_RPLY, WR_REQ, WR_RPLY, DONE);
  - the byte-enable constants BE_LO, BE_HI, BE_WORD.
- One sub-module, qbus_sync: a parameterised-width, SYNC_STAGES-deep synchronizer with reset-to-1 flops, instantiated once for {ad, sync, din, dout, wtbt}.

Test Plan:
- Word DATI at 0o000100, memory returns 16'o123456 with 3-cycle ack latency → mem_addr = 0o40. AD is driven to ~16'o123456 SETUP cycles before RPLY asserts. RPLY and AD are released one cycle after DIN negates.
- Word DATO at 0o000200, data 16'o052525 → mem_wr with mem_be = 11 and mem_wdata = 16'o052525. RPLY asserts after the ack and negates after DOUT.
- DATOB at 0o000201 (wtbt_n = 0 during DOUT) → mem_be = 10. DATOB at 0o000200 → mem_be = 01.
- Address 0o170000 with MASK/BASE as default → no mem_rd/mem_wr, pin_rply_n stays 1, pin_ad_oe stays 0 for the whole frame.
- DATIO at 0o000300: read 16'o000777, then DOUT 16'o001000 in the same SYNC frame → one read, then one write to the same mem_addr, two RPLY pulses.
- pin_rst pulsed during RD_RPLY → pin_rply_n = 1 and pin_ad_oe = 0 immediately. The next SYNC frame completes normally.
